// File: rtl/sm4_sbox_sched.sv
// sm4_sbox_sched
//    Time-shares one 8-bit SM4 S-box between two 32-bit requesters.
//    Port 0 is the round-data path and gets L after substitution.
//    Port 1 is the key-expansion path and gets L' after substitution.
//    A raw request returns the substituted word (tau) without any linear transform.
//    The word is pushed through the S-box one byte per cycle, MSB byte first.
//
//    Ports
//       clk, rst                 core clock, synchronous active-high reset
//       reqN_valid/ready         request handshake; ready is combinational and only in IDLE
//       reqN_word, reqN_raw      input word; raw = 1 skips the linear transform
//       rsp_valid/ready          result handshake; the result is held until accepted
//       rsp_id, rsp_data         issuing port and result word
//       busy                     high whenever the scheduler is not idle
//
//    state | meaning
//    ------+--------------------------------------------------------------
//    IDLE  | waiting for a request; arbitration drives reqN_ready
//    SUB   | substituting byte cnt of the working word, one byte per cycle
//    RESP  | result registered and presented until rsp_ready

module sm4_sbox (
   input  logic [7:0] din,
   output logic [7:0] dout
);
   localparam logic [7:0] SBOX_TABLE [256] = '{
      8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
      8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
      8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
      8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
      8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
      8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
      8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
      8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
      8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
      8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
      8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
      8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
      8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
      8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
      8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
      8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
   };

   assign dout = SBOX_TABLE[din];
endmodule

module sm4_sbox_sched #(
   parameter bit RR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_word,
   input  logic        req0_raw,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_word,
   input  logic        req1_raw,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_data,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, SUB, RESP} state_t;

   state_t      state;
   logic [31:0] work;
   logic        raw_q;
   logic        id_q;
   logic [1:0]  cnt;
   logic        last_gnt;

   logic        gnt0;
   logic        gnt1;
   logic [7:0]  sbox_in;
   logic [7:0]  sbox_out;
   logic [31:0] tau_word;
   logic [31:0] result;

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [31:0] lin_data(input logic [31:0] b);
      return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
   endfunction

   function automatic logic [31:0] lin_key(input logic [31:0] b);
      return b ^ rotl(b, 13) ^ rotl(b, 23);
   endfunction

   // A tie goes to the port that did not win the last accepted grant, so a
   // stalled request never counts as a turn.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state == IDLE) begin
         if (req0_valid && req1_valid) begin
            if (RR_EN && (last_gnt == 1'b0)) begin
               gnt1 = 1'b1;
            end else begin
               gnt0 = 1'b1;
            end
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   always_comb begin
      case (cnt)
         2'd0:    sbox_in = work[31:24];
         2'd1:    sbox_in = work[23:16];
         2'd2:    sbox_in = work[15:8];
         default: sbox_in = work[7:0];
      endcase
   end

   sm4_sbox u_sbox (
      .din  (sbox_in),
      .dout (sbox_out)
   );

   // Only meaningful while cnt == 3: the upper three bytes are already
   // substituted and the last byte is coming out of the S-box this cycle.
   assign tau_word = {work[31:8], sbox_out};

   always_comb begin
      if (raw_q) begin
         result = tau_word;
      end else if (id_q) begin
         result = lin_key(tau_word);
      end else begin
         result = lin_data(tau_word);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         work      <= 32'd0;
         raw_q     <= 1'b0;
         id_q      <= 1'b0;
         cnt       <= 2'd0;
         last_gnt  <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= 32'd0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt0 || gnt1) begin
                  work     <= gnt1 ? req1_word : req0_word;
                  raw_q    <= gnt1 ? req1_raw  : req0_raw;
                  id_q     <= gnt1;
                  last_gnt <= gnt1;
                  cnt      <= 2'd0;
                  busy     <= 1'b1;
                  state    <= SUB;
               end
            end
            SUB: begin
               case (cnt)
                  2'd0:    work[31:24] <= sbox_out;
                  2'd1:    work[23:16] <= sbox_out;
                  2'd2:    work[15:8]  <= sbox_out;
                  default: work[7:0]   <= sbox_out;
               endcase
               cnt <= cnt + 2'd1;
               if (cnt == 2'd3) begin
                  rsp_data  <= result;
                  rsp_id    <= id_q;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sm4_sbox_sched.sv
module tb_sm4_sbox_sched;
   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid, req0_raw, req1_raw, rsp_ready;
   logic [31:0] req0_word, req1_word;

   // index 0: round-robin instance, index 1: fixed-priority instance
   logic        r0 [2];
   logic        r1 [2];
   logic        rv [2];
   logic        rid [2];
   logic        bsy [2];
   logic [31:0] rd [2];

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   bit mon_en = 1'b0;

   bit          m_out  [2];
   int          m_acc  [2];
   bit          m_ptr  [2];
   bit          m_id   [2];
   logic [31:0] m_exp  [2];
   logic [31:0] m_last [2];
   int          gq_rr [$];
   int          gq_fp [$];

   logic [7:0] SB [256] = '{
      8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
      8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
      8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
      8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
      8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
      8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
      8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
      8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
      8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
      8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
      8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
      8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
      8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
      8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
      8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
      8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
   };

   sm4_sbox_sched #(.RR_EN(1'b1)) dut_rr (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(r0[0]), .req0_word(req0_word), .req0_raw(req0_raw),
      .req1_valid(req1_valid), .req1_ready(r1[0]), .req1_word(req1_word), .req1_raw(req1_raw),
      .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_id(rid[0]), .rsp_data(rd[0]), .busy(bsy[0])
   );

   sm4_sbox_sched #(.RR_EN(1'b0)) dut_fp (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(r0[1]), .req0_word(req0_word), .req0_raw(req0_raw),
      .req1_valid(req1_valid), .req1_ready(r1[1]), .req1_word(req1_word), .req1_raw(req1_raw),
      .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_id(rid[1]), .rsp_data(rd[1]), .busy(bsy[1])
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d at cycle %0d: got %h, expected %h", nm, i, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // Whole-word view: substitute all four bytes, then apply the port's transform.
   function automatic logic [31:0] model_result(input logic [31:0] w, input bit raw, input bit port);
      logic [31:0] b;
      for (int k = 0; k < 4; k++) b[8*k +: 8] = SB[w[8*k +: 8]];
      if (raw) return b;
      if (port == 1'b0) return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
      return b ^ rotl(b, 13) ^ rotl(b, 23);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_out[i]  = 1'b0;
         m_acc[i]  = 0;
         m_ptr[i]  = 1'b1;
         m_id[i]   = 1'b0;
         m_exp[i]  = 32'd0;
         m_last[i] = 32'd0;
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < 2; i++) begin
            bit eg0, eg1, ev;
            eg0 = 1'b0;
            eg1 = 1'b0;
            if (!m_out[i]) begin
               if (req0_valid && req1_valid) begin
                  if (i == 0) begin
                     eg0 = m_ptr[i];
                     eg1 = !m_ptr[i];
                  end else begin
                     eg0 = 1'b1;
                  end
               end else begin
                  eg0 = req0_valid;
                  eg1 = req1_valid;
               end
            end
            ev = m_out[i] && ((cyc - m_acc[i]) >= 5);
            chk("req0_ready", i, r0[i], eg0);
            chk("req1_ready", i, r1[i], eg1);
            chk("busy", i, bsy[i], m_out[i]);
            chk("rsp_valid", i, rv[i], ev);
            chk("rsp_data", i, rd[i], ev ? m_exp[i] : m_last[i]);
            if (ev) chk("rsp_id", i, rid[i], m_id[i]);

            if (rst) begin
               m_out[i]  = 1'b0;
               m_ptr[i]  = 1'b1;
               m_last[i] = 32'd0;
            end else if (eg0 || eg1) begin
               m_out[i] = 1'b1;
               m_acc[i] = cyc;
               m_id[i]  = eg1;
               m_ptr[i] = eg1;
               m_exp[i] = eg1 ? model_result(req1_word, req1_raw, 1'b1)
                              : model_result(req0_word, req0_raw, 1'b0);
               if (i == 0) gq_rr.push_back(int'(eg1));
               else        gq_fp.push_back(int'(eg1));
            end else if (ev && rsp_ready) begin
               m_out[i]  = 1'b0;
               m_last[i] = m_exp[i];
            end
         end
      end
   end

   task automatic single(input bit port, input logic [31:0] w, input bit raw, input logic [31:0] exp);
      int lat;
      bit seen;
      if (port) begin
         req1_valid = 1'b1; req1_word = w; req1_raw = raw;
      end else begin
         req0_valid = 1'b1; req0_word = w; req0_raw = raw;
      end
      @(negedge clk);
      chk("accept_ready", 0, port ? r1[0] : r0[0], 1);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_word = ~w; req1_word = ~w;
      lat = 1;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (rv[0]) seen = 1'b1;
         else lat++;
      end
      chk("rsp_seen", 0, seen, 1);
      chk("latency", 0, lat, 5);
      chk("lit_id", 0, rid[0], port);
      chk("lit_data", 0, rd[0], exp);
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_raw = 1'b0;   req1_raw = 1'b0;
      req0_word = 32'd0; req1_word = 32'd0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("reset_rsp_valid", i, rv[i], 0);
         chk("reset_rsp_id", i, rid[i], 0);
         chk("reset_rsp_data", i, rd[i], 0);
         chk("reset_busy", i, bsy[i], 0);
         chk("reset_ready0", i, r0[i], 0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      mon_en = 1'b1;

      single(1'b0, 32'h00010203, 1'b1, 32'hd690e9fe);
      single(1'b0, 32'h7171716c, 1'b0, 32'h01040405);
      single(1'b0, 32'h7171716c, 1'b1, 32'h00000001);
      single(1'b1, 32'h7171716c, 1'b0, 32'h00802001);
      single(1'b1, 32'h00010203, 1'b1, 32'hd690e9fe);

      // both ports continuously valid
      gq_rr.delete();
      gq_fp.delete();
      req0_valid = 1'b1; req0_word = 32'h00112233; req0_raw = 1'b0;
      req1_valid = 1'b1; req1_word = 32'hdeadbeef; req1_raw = 1'b0;
      for (int k = 0; k < 300 && gq_rr.size() < 8; k++) @(negedge clk);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("rr_count", 0, gq_rr.size(), 8);
      chk("fp_count", 1, gq_fp.size(), 8);
      for (int k = 0; k < 8; k++) begin
         if (k < gq_rr.size()) chk("rr_order", 0, gq_rr[k], k % 2);
         if (k < gq_fp.size()) chk("fp_order", 1, gq_fp[k], 0);
      end
      repeat (8) @(posedge clk);
      #1;

      // backpressure with both requesters waiting
      begin
         logic [31:0] hd;
         logic        hid;
         bit          seen;
         rsp_ready = 1'b0;
         req0_valid = 1'b1; req0_word = 32'h01234567; req0_raw = 1'b0;
         @(negedge clk);
         chk("bp_accept", 0, r0[0], 1);
         @(posedge clk); #1;
         req1_valid = 1'b1; req1_word = 32'h89abcdef; req1_raw = 1'b1;
         seen = 1'b0;
         for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (rv[0]) seen = 1'b1;
         end
         chk("bp_rsp_seen", 0, seen, 1);
         hd = rd[0];
         hid = rid[0];
         chk("bp_id", 0, hid, 0);
         for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", 0, rv[0], 1);
            chk("bp_hold_data", 0, rd[0], hd);
            chk("bp_hold_id", 0, rid[0], hid);
            chk("bp_hold_ready0", 0, r0[0], 0);
            chk("bp_hold_ready1", 0, r1[0], 0);
         end
         @(posedge clk); #1;
         rsp_ready = 1'b1;
         @(negedge clk);
         chk("bp_release_valid", 0, rv[0], 1);
         @(posedge clk); #1;
         @(negedge clk);
         chk("bp_idle_valid", 0, rv[0], 0);
         chk("bp_next_rr_gnt1", 0, r1[0], 1);
         chk("bp_next_rr_gnt0", 0, r0[0], 0);
         chk("bp_next_fp_gnt0", 1, r0[1], 1);
         @(posedge clk); #1;
         req0_valid = 1'b0; req1_valid = 1'b0;
         repeat (8) @(posedge clk);
         #1;
      end

      // reset while substituting byte 2
      req0_valid = 1'b1; req0_word = 32'hcafef00d; req0_raw = 1'b0;
      @(negedge clk);
      chk("rst_accept", 0, r0[0], 1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      req0_valid = 1'b1; req0_word = 32'h0badc0de;
      req1_valid = 1'b1; req1_word = 32'h13579bdf;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_busy", i, bsy[i], 0);
         chk("rst_rsp_valid", i, rv[i], 0);
      end
      chk("rst_tie_gnt0", 0, r0[0], 1);
      chk("rst_tie_gnt1", 0, r1[0], 0);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
